mux_operand_feeder: RTL and testbench

- Upstream stage of the 2:1 mux (mux, ports x/y/s/z).
- Buffers operands from two independent valid/ready producers (A, B) into one holding slot each.
- Drives x, y and select s so that z carries one buffered operand per handshake.
- Round-robin between A and B when both are pending; downstream consumes z with out_valid/out_ready.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_operand_feeder_hold_slot.sv | 57 +++++
 rtl/mux_operand_feeder.sv | 117 +++++++++++
 tb/tb_mux_operand_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: types and constants shared by the mux operand feeder.
//   sel_e         - mux select encoding (SEL_X picks x, SEL_Y picks y)
//   MUX_W_DEFAULT - default operand width, matches the downstream mux
//   GRANT_CNT_W   - width of the optional per-channel grant counters
package mux_pkg;

    typedef enum logic {
        SEL_X = 1'b0,
        SEL_Y = 1'b1
    } sel_e;

    localparam int MUX_W_DEFAULT = 4;
    localparam int GRANT_CNT_W   = 8;

endpackage : mux_pkg

// File: rtl/mux_operand_feeder_hold_slot.sv
// hold_slot: one-entry valid/ready holding register.
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - producer offers in_data
//   in_data     - operand to capture
//   in_ready    - slot can take an operand this cycle
//   clear       - the held operand is consumed this cycle
//   full        - slot holds an unconsumed operand
//   data        - held operand; keeps its last value once emptied
// A consume and a capture in the same cycle keep the slot full with the
// new operand, so one operand per cycle can stream through.
module hold_slot
    import mux_pkg::*;
#(
    parameter int n = MUX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    output logic         in_ready,
    input  logic         clear,
    output logic         full,
    output logic [n-1:0] data
);

    logic         full_q, full_d;
    logic [n-1:0] data_q, data_d;
    logic         accept;

    assign in_ready = ~full_q | clear;
    assign accept   = in_valid & in_ready;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule : hold_slot

// File: rtl/mux_operand_feeder.sv
// mux_operand_feeder: buffers operands from two valid/ready producers (A, B)
// into one slot each and drives a 2:1 mux (x, y, s) so that z carries one
// buffered operand per out_valid/out_ready handshake. Round-robin between
// A and B when both slots are full.
//   clk, rst_n          - clock, asynchronous active-low reset
//   a_valid/a_data/a_ready - producer A
//   b_valid/b_data/b_ready - producer B
//   x, y                - slot A / slot B registers, to mux x / y
//   s                   - mux select (0 = x, 1 = y)
//   out_valid/out_ready - downstream handshake on z
// Optional (macro MUX_FEEDER_GRANT_CNT_EN):
//   grant_cnt_a/b       - saturating counts of takes from A / B
module mux_operand_feeder
    import mux_pkg::*;
#(
    parameter int n = MUX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [n-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [n-1:0] b_data,
    output logic         b_ready,
    output logic [n-1:0] x,
    output logic [n-1:0] y,
    output logic         s,
`ifdef MUX_FEEDER_GRANT_CNT_EN
    output logic [GRANT_CNT_W-1:0] grant_cnt_a,
    output logic [GRANT_CNT_W-1:0] grant_cnt_b,
`endif
    output logic         out_valid,
    input  logic         out_ready
);

    logic full_a, full_b;
    logic take;
    logic clear_a, clear_b;
    sel_e sel;
    sel_e last_s_q, last_s_d;

    // Select depends on state only, so it cannot flicker with out_ready.
    always_comb begin
        sel = SEL_X;
        if (full_a && full_b) begin
            sel = (last_s_q == SEL_X) ? SEL_Y : SEL_X;
        end else if (full_b) begin
            sel = SEL_Y;
        end
    end

    assign out_valid = full_a | full_b;
    assign take      = out_valid & out_ready;
    assign clear_a   = take & (sel == SEL_X);
    assign clear_b   = take & (sel == SEL_Y);
    assign s         = sel;

    always_comb begin
        last_s_d = last_s_q;
        if (take) last_s_d = sel;
    end

    // Resetting to SEL_Y makes the first contended grant go to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_s_q <= SEL_Y;
        else        last_s_q <= last_s_d;
    end

    hold_slot #(.n(n)) u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (a_valid),
        .in_data  (a_data),
        .in_ready (a_ready),
        .clear    (clear_a),
        .full     (full_a),
        .data     (x)
    );

    hold_slot #(.n(n)) u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_valid),
        .in_data  (b_data),
        .in_ready (b_ready),
        .clear    (clear_b),
        .full     (full_b),
        .data     (y)
    );

`ifdef MUX_FEEDER_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [GRANT_CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (clear_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
        if (clear_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign grant_cnt_a = cnt_a_q;
    assign grant_cnt_b = cnt_b_q;
`endif

endmodule : mux_operand_feeder

// File: tb/tb_mux_operand_feeder.sv
// Bench for mux_operand_feeder: directed steps plus random traffic checked
// against a queue-based reference model of the two producers' operands.
module tb_mux_operand_feeder;
    import mux_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [N-1:0] a_data = '0, b_data = '0;
    logic         a_ready, b_ready, s, out_valid;
    logic [N-1:0] x, y;
`ifdef MUX_FEEDER_GRANT_CNT_EN
    logic [7:0]   grant_cnt_a, grant_cnt_b;
`endif

    mux_operand_feeder #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .x         (x),
        .y         (y),
        .s         (s),
`ifdef MUX_FEEDER_GRANT_CNT_EN
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: operands waiting per channel, last value seen per
    // channel (what x/y must show), which channel was served last, and
    // how many operands each channel has delivered.
    logic [N-1:0] q_a[$];
    logic [N-1:0] q_b[$];
    logic [N-1:0] last_val_a, last_val_b;
    bit           served_b_last;
    int           served_a, served_b;

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        last_val_a    = '0;
        last_val_b    = '0;
        served_b_last = 1'b1;
        served_a      = 0;
        served_b      = 0;
    endtask

    // Channel the model would serve now: alternate when both wait,
    // otherwise whichever waits; A when idle.
    function automatic bit pick_b();
        if (q_a.size() > 0 && q_b.size() > 0) return !served_b_last;
        return (q_b.size() > 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit pend = (q_a.size() > 0) || (q_b.size() > 0);
        bit sb   = pick_b();
        bit tk   = pend && out_ready;
        check("x", 32'(x), 32'(last_val_a));
        check("y", 32'(y), 32'(last_val_b));
        check("s", 32'(s), 32'(sb));
        check("out_valid", 32'(out_valid), 32'(pend));
        check("a_ready", 32'(a_ready), 32'(q_a.size() == 0 || (tk && !sb)));
        check("b_ready", 32'(b_ready), 32'(q_b.size() == 0 || (tk && sb)));
        if (pend) check("z", 32'(s ? y : x), 32'(sb ? q_b[0] : q_a[0]));
`ifdef MUX_FEEDER_GRANT_CNT_EN
        check("grant_cnt_a", 32'(grant_cnt_a), 32'(served_a > 255 ? 255 : served_a));
        check("grant_cnt_b", 32'(grant_cnt_b), 32'(served_b > 255 ? 255 : served_b));
`endif
    endtask

    // One clock: drive inputs just after an edge, check mid-cycle, then
    // advance the model across the next rising edge.
    task automatic cycle(input bit av, input logic [N-1:0] ad,
                         input bit bv, input logic [N-1:0] bd, input bit ordy);
        bit pend, sb, tk, acc_a, acc_b;
        a_valid = av; a_data = ad;
        b_valid = bv; b_data = bd;
        out_ready = ordy;
        #3;
        check_outputs();
        pend  = (q_a.size() > 0) || (q_b.size() > 0);
        sb    = pick_b();
        tk    = pend && ordy;
        acc_a = av && (q_a.size() == 0 || (tk && !sb));
        acc_b = bv && (q_b.size() == 0 || (tk && sb));
        @(posedge clk);
        if (tk) begin
            if (sb) begin void'(q_b.pop_front()); served_b++; end
            else    begin void'(q_a.pop_front()); served_a++; end
            served_b_last = sb;
        end
        if (acc_a) begin q_a.push_back(ad); last_val_a = ad; end
        if (acc_b) begin q_b.push_back(bd); last_val_b = bd; end
        #1;
    endtask

    initial begin
        model_reset();

        // Reset held with producers active: nothing captured.
        a_valid = 1'b1; a_data = 4'h7;
        b_valid = 1'b1; b_data = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        check("rst x", 32'(x), 32'h0);
        check("rst y", 32'(y), 32'h0);
        check("rst s", 32'(s), 32'h0);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst a_ready", 32'(a_ready), 32'h1);
        check("rst b_ready", 32'(b_ready), 32'h1);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single A, held, then taken.
        cycle(1, 4'hA, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("single x", 32'(x), 32'hA);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Both pending: A first, then B.
        cycle(1, 4'h3, 1, 4'hC, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Back-pressure with producers still offering data.
        cycle(1, 4'h5, 1, 4'h6, 0);
        for (int i = 0; i < 5; i++) cycle(1, 4'(i), 1, 4'(i + 8), 0);
        check("bp x", 32'(x), 32'h5);
        check("bp y", 32'(y), 32'h6);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

        // Streaming A at full rate.
        for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Long A stream (drives the A grant counter past saturation).
        for (int i = 0; i < 300; i++) cycle(1, 4'($urandom), 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));

        // Both sustained full: strict alternation.
        for (int i = 0; i < 12; i++) cycle(1, 4'($urandom), 1, 4'($urandom), 1);

        // Asynchronous reset between edges with both slots full.
        cycle(1, 4'hE, 1, 4'hD, 0);
        cycle(0, 0, 0, 0, 0);
        check("pre-rst out_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'h0);
        check("async rst x", 32'(x), 32'h0);
`ifdef MUX_FEEDER_GRANT_CNT_EN
        check("async rst cnt_a", 32'(grant_cnt_a), 32'h0);
        check("async rst cnt_b", 32'(grant_cnt_b), 32'h0);
`endif
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First contended grant after reset goes to A.
        cycle(1, 4'h1, 1, 4'h2, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_operand_feeder
